// File: rtl/signed_sum_display.sv
// signed_sum_display: captures a 5-bit two's-complement sum on a load strobe
// and scans it as sign/tens/ones onto a 4-digit common-anode 7-seg display.
// Build option: define SUM_DISPLAY_ZERO_BLANK_EN to blank a zero tens digit.
module signed_sum_display #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] sum,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int            CW      = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

  // Digit codes beyond 0..9 used internally for the non-numeric glyphs.
  localparam logic [3:0] D_MINUS = 4'hA;
  localparam logic [3:0] D_BLANK = 4'hF;

  logic [4:0]    val;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic       neg;
  logic [4:0] mag;
  logic       tens;
  logic [3:0] ones;
  logic [3:0] dig;
  logic [3:0] an_nxt;

  // Active-low segment pattern {g,f,e,d,c,b,a} for a digit code.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      D_MINUS: s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Sign/magnitude and decimal split of the held value. Magnitude tops out at
  // 16, so tens is a single bit; ones is done mod 16, which maps 16 -> 6.
  always_comb begin
    neg  = val[4];
    mag  = neg ? (5'd0 - val) : val;
    tens = (mag >= 5'd10);
    ones = tens ? (mag[3:0] - 4'd10) : mag[3:0];
  end

  // Pick the glyph for the currently selected digit position.
  always_comb begin
    dig = D_BLANK;
    case (idx)
      2'd0: dig = ones;
`ifdef SUM_DISPLAY_ZERO_BLANK_EN
      2'd1: dig = tens ? 4'd1 : D_BLANK;
`else
      2'd1: dig = {3'b000, tens};
`endif
      2'd2: dig = neg ? D_MINUS : D_BLANK;
      default: dig = D_BLANK;
    endcase
    an_nxt = ~(4'b0001 << idx);
  end

  // Capture, refresh scan and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
      cnt <= '0;
      idx <= '0;
      an  <= 4'b1111;
      seg <= 7'b1111111;
    end else begin
      if (load) val <= sum;
      an  <= an_nxt;
      seg <= seg7(dig);
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_signed_sum_display.sv
// Directed bench for signed_sum_display with REFRESH_DIV=4: a table of values
// scanned over a full frame, plus hand sequences for reset, load-at-wrap,
// reset mid-scan and load held high.
module tb_signed_sum_display;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S6  = 7'b0000010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] MIN = 7'b0111111;
  localparam logic [6:0] BLK = 7'b1111111;
`ifdef SUM_DISPLAY_ZERO_BLANK_EN
  localparam logic [6:0] TZ = BLK;
`else
  localparam logic [6:0] TZ = S0;
`endif

  typedef struct {
    string      name;
    logic [4:0] sum;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [4:0] sum = '0;
  logic [3:0] an;
  logic [6:0] seg;

  int tests = 0;
  int fails = 0;

  signed_sum_display #(.REFRESH_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .load(load),
    .sum (sum),
    .an  (an),
    .seg (seg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] ea, input logic [6:0] es);
    tests++;
    if (an !== ea || seg !== es) begin
      fails++;
      $display("FAIL %s: got an=%b seg=%b, want an=%b seg=%b", name, an, seg, ea, es);
    end
  endtask

  // One reset edge, leaving rst low afterwards.
  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    int d;

    vecs[0] = '{"p15",  5'b01111, S5, S1, BLK};
    vecs[1] = '{"m16",  5'b10000, S6, S1, MIN};
    vecs[2] = '{"m3",   5'b11101, S3, TZ, MIN};
    vecs[3] = '{"p5",   5'b00101, S5, TZ, BLK};
    vecs[4] = '{"zero", 5'b00000, S0, TZ, BLK};
    vecs[5] = '{"m9",   5'b10111, S9, TZ, MIN};
    vecs[6] = '{"p10",  5'b01010, S0, S1, BLK};
    vecs[7] = '{"m1",   5'b11111, S1, TZ, MIN};
    vecs[8] = '{"m10",  5'b10110, S0, S1, MIN};

    // Reset held for two cycles: dark, then digit 0 of value 0, then idx1.
    rst = 1'b1;
    tick();
    chk("rst_dark1", 4'b1111, BLK);
    tick();
    chk("rst_dark2", 4'b1111, BLK);
    rst = 1'b0;
    tick();
    chk("rst_first", 4'b1110, S0);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_dwell", 4'b1110, S0);
    tick();
    chk("rst_idx1", 4'b1101, TZ);

    // Table: reset, load at E1, then check every cycle E2..E17 of the frame.
    foreach (vecs[v]) begin
      do_reset();
      load = 1'b1; sum = vecs[v].sum;
      tick();
      load = 1'b0; sum = 5'b01001;
      for (int k = 2; k <= 17; k++) begin
        tick();
        d = ((k - 1) / 4) % 4;
        ea = ~(4'b0001 << d);
        case (d)
          0: es = vecs[v].s0;
          1: es = vecs[v].s1;
          2: es = vecs[v].s2;
          default: es = BLK;
        endcase
        chk($sformatf("%s_e%0d", vecs[v].name, k), ea, es);
      end
    end

    // Load exactly on the wrap from idx3 cnt3: next output is idx0 with the new value.
    do_reset();
    for (int i = 1; i <= 15; i++) tick();
    chk("wrap_pre", 4'b0111, BLK);
    load = 1'b1; sum = 5'b00111;
    tick();
    load = 1'b0;
    chk("wrap_edge", 4'b0111, BLK);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wrap_dwell%0d", i), 4'b1110, S7);
    end
    tick();
    chk("wrap_idx1", 4'b1101, TZ);

    // Reset mid-scan on idx2 showing -9; a simultaneous load is ignored.
    do_reset();
    load = 1'b1; sum = 5'b10111;
    tick();
    load = 1'b0;
    for (int i = 2; i <= 9; i++) tick();
    chk("mid_minus", 4'b1011, MIN);
    rst = 1'b1; load = 1'b1; sum = 5'b00101;
    tick();
    chk("mid_dark", 4'b1111, BLK);
    rst = 1'b0; load = 1'b0;
    tick();
    chk("mid_zero", 4'b1110, S0);
    for (int i = 0; i < 3; i++) tick();
    chk("mid_dwell", 4'b1110, S0);
    tick();
    chk("mid_idx1", 4'b1101, TZ);

    // Load held high: val follows sum every cycle, one cycle behind on display.
    do_reset();
    load = 1'b1; sum = 5'b00011;
    tick();
    sum = 5'b01100;
    tick();
    chk("hold_a", 4'b1110, S3);
    sum = 5'b11110;
    tick();
    chk("hold_b", 4'b1110, S2);
    load = 1'b0;
    tick();
    chk("hold_c", 4'b1110, S2);
    for (int i = 0; i < 4; i++) tick();
    chk("hold_tens", 4'b1101, TZ);
    for (int i = 0; i < 4; i++) tick();
    chk("hold_sign", 4'b1011, MIN);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/signed_sum_display.md
# signed_sum_display

Display-side consumer of the 4-bit signed adder/subtractor's 5-bit two's-complement result.
- Captures a result on a load strobe.
- Converts it to sign and magnitude, then to decimal digits.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the arithmetic datapath and the board display pins; it is the read end of the adder's `sum` output.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000 — clock cycles each digit stays selected; legal range ≥ 2.

Ports:
- `clk`  input  1  — system clock; all state updates on the rising edge.
- `rst`  input  1  — synchronous reset, active-high.
- `load`  input  1  — capture strobe; `sum` is sampled on any rising edge where `load`=1.
- `sum`  input  5  — two's-complement value, range −16..+15.
- `an`  output  4  — digit anodes, active-low; `an[0]` is the rightmost digit.
- `seg`  output  7  — segments `{g,f,e,d,c,b,a}`, active-low.

## Operation
Registers:
- `val` (5 b): held value.
- `cnt`: refresh counter, width `$clog2(REFRESH_DIV)`.
- `idx` (2 b): digit index.
- `an`, `seg`: outputs, both registered.

Capture:
- `load`=1 ⇒ `val` ← `sum`.
- `load` does not disturb `cnt` or `idx`.

Conversion (combinational from `val`):
- `neg` = `val[4]`.
- `mag` (5 b) = `neg ? −val : val`, range 0..16.
- `tens` = `mag`/10 (0 or 1).
- `ones` = `mag`%10.

Digit map by `idx`:
- 0: `ones`.
- 1: `tens`; leading-zero handling per Configuration.
- 2: minus if `neg`, else blank.
- 3: always blank.

Segment codes:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- minus=0111111, blank=1111111

Anodes:
- `an` = one-cold of `idx`: idx0 → 1110, idx1 → 1101, idx2 → 1011, idx3 → 0111.
- A blank digit still drives its anode low, with all segments off.

Refresh:
- `cnt` increments every cycle.
- When `cnt` = `REFRESH_DIV`−1: `cnt` ← 0 and `idx` ← `idx`+1, wrapping 3 → 0.

## Timing
- Reset values (edge after `rst`=1):
  - `val`=0, `cnt`=0, `idx`=0.
  - `an`=1111, `seg`=1111111, i.e. dark for exactly one cycle.
- First cycle after reset: outputs show digit 0 of value 0 (`an`=1110, `seg`=1000000).
- Output latency: `an`/`seg` at edge k+1 reflect `idx` and `val` as they were after edge k.
  - So a load at edge k is visible at edge k+1, only if the selected digit depends on it.
- `load` and `cnt` wrap in the same cycle:
  - both take effect;
  - the next output uses the new `idx` with the new `val`.
- `load` held high: `val` tracks `sum` every cycle.
- `rst` has priority over `load` and refresh.
  - Reset mid-scan returns to idx0 with `cnt`=0 and discards `val`.
- Dwell per digit is exactly `REFRESH_DIV` cycles; full frame is 4·`REFRESH_DIV`.

## Configuration
- Macro: `SUM_DISPLAY_ZERO_BLANK_EN`.
- Defined:
  - digit 1 shows blank when `tens`=0;
  - the minus sign stays on digit 2, so −5 displays as "␣-␣5".
- Undefined:
  - digit 1 always shows `tens`, including 0, so +5 displays as "␣␣05".
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `REFRESH_DIV`=4.

1. **Reset.** Assert `rst` for 2 cycles, then release.
   - `an`=1111 and `seg`=1111111 during reset.
   - Next cycle: `an`=1110, `seg`=1000000.
   - After 4 cycles: `an`=1101.
2. **Positive value.** `load` with `sum`=01111 (+15); run one full frame of 16 cycles.
   - idx0: `seg`=0010010 ("5").
   - idx1: `seg`=1111001 ("1").
   - idx2: blank.
   - idx3: blank.
3. **Most negative value.** `load` with `sum`=10000 (−16).
   - idx0: "6" (0000010).
   - idx1: "1".
   - idx2: minus (0111111).
4. **Leading zero.** `load` with `sum`=11101 (−3).
   - idx0: "3".
   - idx2: minus.
   - idx1: blank with `SUM_DISPLAY_ZERO_BLANK_EN` defined; "0" (1000000) without it.
5. **Load at wrap.** Pulse `load` (`sum`=00111, +7) on the cycle `cnt`=3 while `idx`=3.
   - Next output: `an`=1110, `seg`=1111000 ("7").
   - Dwell remains 4 cycles.
6. **Reset mid-scan.** Assert `rst` while `idx`=2 and `val`=−9.
   - Outputs go dark for one cycle.
   - Display then shows value 0 on idx0.
   - `load` asserted together with `rst` is ignored.
